// File: rtl/divider_remainder.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A 2*WIDTH remainder register holds partial remainder (high) and quotient bits (low).
module divider_remainder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic [WIDTH-1:0] Quotient_out,
    output logic [WIDTH-1:0] Remainder_out,
    output logic             Ready,
    output logic             Busy,
    output logic             DivZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [2*WIDTH-1:0] rem;
    logic [WIDTH-1:0]   dreg;
    logic [CW-1:0]      count;
    logic               dz;

    logic load;
    logic load_zero;
    logic step;

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // State register; Reset drops any in-flight division.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control; start only matters in IDLE or DONE.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_zero  = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (Divisor_in == '0) begin
                        load_zero  = 1'b1;
                        next_state = DONE;
                    end else begin
                        load       = 1'b1;
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Trial subtraction: the shifted partial remainder needs WIDTH+1 bits,
    // and the top bit of the difference is the borrow.
    always_comb begin
        shifted = {rem, 1'b0};
        upper   = shifted[2*WIDTH:WIDTH];
        diff    = upper - {1'b0, dreg};
        borrow  = diff[WIDTH];
    end

    // Remainder/quotient register, divisor register, iteration counter.
    always_ff @(posedge clk) begin
        if (Reset) begin
            rem   <= '0;
            dreg  <= '0;
            count <= '0;
            dz    <= 1'b0;
        end else if (load) begin
            rem   <= {{WIDTH{1'b0}}, Dividend_in};
            dreg  <= Divisor_in;
            count <= '0;
            dz    <= 1'b0;
        end else if (load_zero) begin
            rem   <= {Dividend_in, {WIDTH{1'b1}}};
            dreg  <= '0;
            count <= '0;
            dz    <= 1'b1;
        end else if (step) begin
            if (!borrow) begin
                rem <= {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            end else begin
                rem <= {shifted[2*WIDTH-1:1], 1'b0};
            end
            count <= count + 1'b1;
        end
    end

    // Outputs decode from state and registers only.
    always_comb begin
        Ready         = (state == DONE);
        Busy          = (state == RUN);
        DivZero       = dz;
        Quotient_out  = Ready ? rem[WIDTH-1:0] : '0;
        Remainder_out = Ready ? rem[2*WIDTH-1:WIDTH] : '0;
    end

endmodule

// File: tb/tb_divider_remainder.sv
// Directed bench for divider_remainder: latency, results, divide-by-zero,
// reset abort and back-to-back restart from DONE.
module tb_divider_remainder;

    logic        clk;
    logic        Reset;
    logic        start;
    logic [31:0] Dividend_in;
    logic [31:0] Divisor_in;
    logic [31:0] Quotient_out;
    logic [31:0] Remainder_out;
    logic        Ready;
    logic        Busy;
    logic        DivZero;

    int total = 0;
    int bad   = 0;
    int both  = 0;

    divider_remainder #(.WIDTH(32)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .start        (start),
        .Dividend_in  (Dividend_in),
        .Divisor_in   (Divisor_in),
        .Quotient_out (Quotient_out),
        .Remainder_out(Remainder_out),
        .Ready        (Ready),
        .Busy         (Busy),
        .DivZero      (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present operands, take the accept edge, drop start.
    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        Dividend_in = a;
        Divisor_in  = b;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for Ready; optionally toggle start during RUN.
    task automatic wait_ready(input bit toggle, output int lat,
                              output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!Ready && lat < 100) begin
            if (Busy) busy_n++;
            if (toggle) begin
                start       = lat[0];
                Dividend_in = 32'd1;
                Divisor_in  = 32'd1;
            end
            @(posedge clk);
            #1;
            if (Ready && Busy) both++;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic divide(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] q,
                          input logic [31:0] r);
        int lat;
        int bn;
        accept(a, b);
        wait_ready(1'b0, lat, bn);
        chk({tag, "_lat"}, lat, 32);
        chk({tag, "_q"}, Quotient_out, q);
        chk({tag, "_r"}, Remainder_out, r);
        chk({tag, "_dz"}, {31'b0, DivZero}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int bn;

        vecs[0] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0};
        vecs[1] = '{32'd5, 32'd9, 32'd0, 32'd5};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        vecs[3] = '{32'd1000000, 32'd1000, 32'd1000, 32'd0};
        vecs[4] = '{32'd0, 32'd5, 32'd0, 32'd0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0};
        vecs[6] = '{32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF};
        vecs[7] = '{32'd7, 32'd2, 32'd3, 32'd1};

        Reset       = 1'b1;
        start       = 1'b0;
        Dividend_in = '0;
        Divisor_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, Ready}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_dz", {31'b0, DivZero}, 32'd0);
        chk("rst_q", Quotient_out, 32'd0);
        chk("rst_r", Remainder_out, 32'd0);
        Reset = 1'b0;
        @(posedge clk);
        #1;

        // 100 / 7 with latency and busy-length checks
        accept(32'd100, 32'd7);
        chk("t1_busy0", {31'b0, Busy}, 32'd1);
        wait_ready(1'b0, lat, bn);
        chk("t1_lat", lat, 32);
        chk("t1_busyn", bn, 32);
        chk("t1_q", Quotient_out, 32'd14);
        chk("t1_r", Remainder_out, 32'd2);
        chk("t1_dz", {31'b0, DivZero}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_hold_q", Quotient_out, 32'd14);
        chk("t1_hold_r", Remainder_out, 32'd2);
        chk("t1_hold_rdy", {31'b0, Ready}, 32'd1);

        foreach (vecs[i]) begin
            divide($sformatf("v%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r);
        end

        // divide by zero
        accept(32'd1234, 32'd0);
        chk("dz_rdy", {31'b0, Ready}, 32'd1);
        chk("dz_busy", {31'b0, Busy}, 32'd0);
        chk("dz_q", Quotient_out, 32'hFFFF_FFFF);
        chk("dz_r", Remainder_out, 32'd1234);
        chk("dz_flag", {31'b0, DivZero}, 32'd1);
        divide("after_dz", 32'd9, 32'd4, 32'd2, 32'd1);

        // reset during RUN
        accept(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        chk("ab_busy", {31'b0, Busy}, 32'd1);
        Reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ab_rdy", {31'b0, Ready}, 32'd0);
        chk("ab_busy2", {31'b0, Busy}, 32'd0);
        chk("ab_q", Quotient_out, 32'd0);
        chk("ab_r", Remainder_out, 32'd0);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        divide("ab_new", 32'd50, 32'd6, 32'd8, 32'd2);

        // back-to-back from DONE with start toggling during RUN
        divide("b2b_a", 32'd100, 32'd7, 32'd14, 32'd2);
        accept(32'd81, 32'd9);
        chk("b2b_drop", {31'b0, Ready}, 32'd0);
        chk("b2b_busy", {31'b0, Busy}, 32'd1);
        wait_ready(1'b1, lat, bn);
        chk("b2b_lat", lat, 32);
        chk("b2b_q", Quotient_out, 32'd9);
        chk("b2b_r", Remainder_out, 32'd0);

        chk("excl", both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
